stream_credit_tx: RTL and testbench

- Transmitter end of a credit-based link.
- Accepts beats from an upstream valid/ready producer and launches them downstream as registered valid+data, with no downstream ready.
- Downstream flow control uses credits. The receiver buffer returns one credit pulse per beat it frees.
- Sits in front of any receive buffer of CREDITS entries, so the long-haul path carries no combinational ready.

---
 rtl/stream_credit_tx.sv | 92 +++++++++
 tb/tb_stream_credit_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stream_credit_tx.sv
// stream_credit_tx
//   Transmitter end of a credit-based link. Beats accepted from an upstream
//   valid/ready producer are launched downstream as a registered valid+data
//   pulse. The downstream side has no ready; instead, the receiver returns
//   one credit pulse per buffer entry it frees. Because ready_in is derived
//   only from the local credit register, the long-haul path carries no
//   combinational ready.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset (0 = in reset)
//   valid_in       in   upstream beat valid
//   ready_in       out  a beat can be accepted this cycle (credit_cnt != 0)
//   data_in        in   upstream payload
//   valid_out      out  one-cycle downstream strobe per launched beat
//   data_out       out  downstream payload, meaningful when valid_out=1
//   credit_return  in   receiver freed one entry this cycle
//   credits_avail  out  current credit count
//   credit_err     out  sticky: credit returned while count already full
module stream_credit_tx #(
  parameter type         T       = logic [7:0],
  parameter int unsigned CREDITS = 2,
  parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          ready_in,
  input  T              data_in,
  output logic          valid_out,
  output T              data_out,
  input  logic          credit_return,
  output logic [CW-1:0] credits_avail,
  output logic          credit_err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(CREDITS);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] r_credit_cnt;
  logic          r_valid;
  T              r_data;
  logic          r_err;

  logic          w_accept;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_overflow;

  assign ready_in      = (r_credit_cnt != '0);
  assign w_accept      = valid_in && ready_in;
  assign valid_out     = r_valid;
  assign data_out      = r_data;
  assign credits_avail = r_credit_cnt;
  assign credit_err    = r_err;

  // A return that coincides with an accept is consumed by that accept, so
  // only a lone return against a full counter counts as an overflow.
  always_comb begin
    w_cnt_nxt  = r_credit_cnt;
    w_overflow = 1'b0;
    case ({w_accept, credit_return})
      2'b10: w_cnt_nxt = r_credit_cnt - ONE;
      2'b01: begin
        if (r_credit_cnt == MAX_CNT) begin
          w_overflow = 1'b1;
        end else begin
          w_cnt_nxt = r_credit_cnt + ONE;
        end
      end
      default: w_cnt_nxt = r_credit_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit_cnt <= MAX_CNT;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_valid      <= w_accept;
      r_credit_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_data <= data_in;
      end
      if (w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_credit_tx.sv
module tb_stream_credit_tx;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_in;
  logic       valid_out;
  logic [7:0] data_out;
  logic       credit_return;
  logic [1:0] credits_avail;
  logic       credit_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  stream_credit_tx #(
    .T      (logic [7:0]),
    .CREDITS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .credit_return(credit_return),
    .credits_avail(credits_avail),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic [1:0] cnt,
                           input logic vo, input logic [7:0] dout, input logic err);
    check({tag, ".ready_in"},      {31'd0, ready_in},      {31'd0, rdy});
    check({tag, ".credits_avail"}, {30'd0, credits_avail}, {30'd0, cnt});
    check({tag, ".valid_out"},     {31'd0, valid_out},     {31'd0, vo});
    check({tag, ".data_out"},      {24'd0, data_out},      {24'd0, dout});
    check({tag, ".credit_err"},    {31'd0, credit_err},    {31'd0, err});
  endtask

  initial begin
    reset         = 1'b0;
    valid_in      = 1'b0;
    data_in       = 8'h00;
    credit_return = 1'b0;

    // Reset held for two cycles, then released
    step();
    check_all("rst_c1", 1'b1, 2'd2, 1'b0, 8'h00, 1'b0);
    step();
    check_all("rst_c2", 1'b1, 2'd2, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    step();
    check_all("rst_rel", 1'b1, 2'd2, 1'b0, 8'h00, 1'b0);

    // Starvation: 0x11, 0x22 launch back-to-back, 0x33 stalls
    valid_in = 1'b1;
    data_in  = 8'h11;
    step();
    check_all("starve_b0", 1'b1, 2'd1, 1'b1, 8'h11, 1'b0);
    data_in = 8'h22;
    step();
    check_all("starve_b1", 1'b0, 2'd0, 1'b1, 8'h22, 1'b0);
    data_in = 8'h33;
    step();
    check_all("starve_hold1", 1'b0, 2'd0, 1'b0, 8'h22, 1'b0);
    step();
    check_all("starve_hold2", 1'b0, 2'd0, 1'b0, 8'h22, 1'b0);

    // Refill: one credit pulse lets the stalled 0x33 through
    credit_return = 1'b1;
    step();
    check_all("refill_ret", 1'b1, 2'd1, 1'b0, 8'h22, 1'b0);
    credit_return = 1'b0;
    step();
    check_all("refill_acc", 1'b0, 2'd0, 1'b1, 8'h33, 1'b0);
    valid_in = 1'b0;
    step();
    check_all("refill_idle", 1'b0, 2'd0, 1'b0, 8'h33, 1'b0);

    // Restore full credit
    credit_return = 1'b1;
    step();
    check_all("restore1", 1'b1, 2'd1, 1'b0, 8'h33, 1'b0);
    step();
    check_all("restore2", 1'b1, 2'd2, 1'b0, 8'h33, 1'b0);
    credit_return = 1'b0;

    // Streaming: the receiver returns each beat's credit in the cycle it
    // observes valid_out, so the count never reaches zero.
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in       = 8'(i);
      credit_return = valid_out;
      step();
      check($sformatf("stream%0d.ready_in", i),  {31'd0, ready_in},  32'd1);
      check($sformatf("stream%0d.valid_out", i), {31'd0, valid_out}, 32'd1);
      check($sformatf("stream%0d.data_out", i),  {24'd0, data_out},  i);
      check($sformatf("stream%0d.credits", i),   {30'd0, credits_avail}, 32'd1);
    end
    valid_in      = 1'b0;
    credit_return = valid_out;
    step();
    check_all("stream_drain", 1'b1, 2'd2, 1'b0, 8'h09, 1'b0);
    credit_return = 1'b0;

    // Simultaneous accept + return at full count: no error
    valid_in      = 1'b1;
    data_in       = 8'hA5;
    credit_return = 1'b1;
    step();
    check_all("simul", 1'b1, 2'd2, 1'b1, 8'hA5, 1'b0);

    // Lone return at full count: saturate and flag
    valid_in = 1'b0;
    step();
    check_all("overflow", 1'b1, 2'd2, 1'b0, 8'hA5, 1'b1);
    credit_return = 1'b0;
    step();
    check_all("err_sticky", 1'b1, 2'd2, 1'b0, 8'hA5, 1'b1);

    // Drain credits with two beats, then reset between clock edges
    valid_in = 1'b1;
    data_in  = 8'h5A;
    step();
    check_all("pre_rst_b0", 1'b1, 2'd1, 1'b1, 8'h5A, 1'b1);
    data_in = 8'h6B;
    step();
    check_all("pre_rst_b1", 1'b0, 2'd0, 1'b1, 8'h6B, 1'b1);
    valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 1'b1, 2'd2, 1'b0, 8'h00, 1'b0);
    step();
    reset = 1'b1;
    step();
    check_all("post_rst", 1'b1, 2'd2, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
